// File: rtl/sequence_generator_serializer_if.sv
// Handshake and serial-output bundle for sequence_generator_serializer.
// master drives frame requests; slave is the serializer.
interface sequence_generator_serializer_if #(
  parameter int PATTERN_W = 7,
  parameter int COUNT_W   = 8,
  parameter int GAP_W     = 4
) ();
  logic                 start;
  logic                 abort;
  logic [PATTERN_W-1:0] pattern_in;
  logic [COUNT_W-1:0]   repeat_cnt;
  logic [GAP_W-1:0]     gap_len;
  logic                 data_out;
  logic                 data_valid;
  logic                 frame_start;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, pattern_in,
    output repeat_cnt, gap_len,
    input  data_out, data_valid,
    input  frame_start, busy, done
  );

  modport slave (
    input  start, abort, pattern_in,
    input  repeat_cnt, gap_len,
    output data_out, data_valid,
    output frame_start, busy, done
  );
endinterface

// File: rtl/sequence_generator_serializer.sv
// MSB-first pattern serializer with repeat count and idle gaps.
// SEQ_GEN_PRBS_FILL_EN: gap bits come from a x^7+x^6+1 LFSR, else 0.
module sequence_generator_serializer #(
  parameter int PATTERN_W = 7,
  parameter int COUNT_W   = 8,
  parameter int GAP_W     = 4
) (
  input logic clk,
  input logic reset,
  sequence_generator_serializer_if.slave bus
);

  localparam int BW = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(PATTERN_W - 1);
  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [COUNT_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]     gcnt_q, gcnt_d;
  logic [GAP_W-1:0]     glen_q, glen_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [PATTERN_W-1:0] sh_q, sh_d;
  logic                 out_q, out_d;
  logic                 vld_q, vld_d;
  logic                 fs_q, fs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fill;

`ifdef SEQ_GEN_PRBS_FILL_EN
  logic [6:0] lfsr_q;
  logic       seed_lfsr, step_lfsr;

  // Fill generator: reseeded per frame, stepped once per gap bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lfsr_q <= 7'h7F;
    else if (seed_lfsr)
      lfsr_q <= 7'h7F;
    else if (step_lfsr)
      lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  assign fill = lfsr_q[6];
`else
  assign fill = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gcnt_d  = gcnt_q;
    glen_d  = glen_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    out_d   = 1'b0;
    vld_d   = 1'b0;
    fs_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SEQ_GEN_PRBS_FILL_EN
    seed_lfsr = 1'b0;
    step_lfsr = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d  = bus.pattern_in;
          glen_d = bus.gap_len;
          rep_d  = bus.repeat_cnt;
`ifdef SEQ_GEN_PRBS_FILL_EN
          seed_lfsr = 1'b1;
`endif
          if (bus.repeat_cnt != '0) begin
            state_d = SEND;
            bit_d   = '0;
            out_d   = bus.pattern_in[PATTERN_W-1];
            sh_d    = bus.pattern_in << 1;
            vld_d   = 1'b1;
            fs_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bit_q != LAST) begin
          bit_d  = bit_q + 1'b1;
          out_d  = sh_q[PATTERN_W-1];
          sh_d   = sh_q << 1;
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end else if (rep_q != ONE) begin
          rep_d  = rep_q - 1'b1;
          vld_d  = 1'b1;
          busy_d = 1'b1;
          if (glen_q != '0) begin
            state_d = GAP;
            gcnt_d  = GAP_W'(1);
            out_d   = fill;
`ifdef SEQ_GEN_PRBS_FILL_EN
            step_lfsr = 1'b1;
`endif
          end else begin
            bit_d = '0;
            out_d = pat_q[PATTERN_W-1];
            sh_d  = pat_q << 1;
            fs_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (gcnt_q != glen_q) begin
          gcnt_d = gcnt_q + 1'b1;
          out_d  = fill;
          vld_d  = 1'b1;
          busy_d = 1'b1;
`ifdef SEQ_GEN_PRBS_FILL_EN
          step_lfsr = 1'b1;
`endif
        end else begin
          state_d = SEND;
          bit_d   = '0;
          out_d   = pat_q[PATTERN_W-1];
          sh_d    = pat_q << 1;
          vld_d   = 1'b1;
          fs_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      rep_q   <= '0;
      gcnt_q  <= '0;
      glen_q  <= '0;
      pat_q   <= '0;
      sh_q    <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gcnt_q  <= gcnt_d;
      glen_q  <= glen_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out    = out_q;
  assign bus.data_valid  = vld_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_sequence_generator_serializer.sv
// Randomized bench for sequence_generator_serializer.
// Expected stream derived from frame arithmetic (period = W + G).
module tb_sequence_generator_serializer;

  localparam int W  = 7;
  localparam int CW = 8;
  localparam int GW = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  sequence_generator_serializer_if #(
    .PATTERN_W(W), .COUNT_W(CW), .GAP_W(GW)
  ) bus ();

  sequence_generator_serializer #(
    .PATTERN_W(W), .COUNT_W(CW), .GAP_W(GW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // {valid, frame_start, busy, done, data}
  function automatic logic [4:0] obs();
    return {bus.data_valid, bus.frame_start,
            bus.busy, bus.done, bus.data_out};
  endfunction

  function automatic logic fill_bit(input int k);
`ifdef SEQ_GEN_PRBS_FILL_EN
    logic [6:0] l;
    l = 7'h7F;
    for (int i = 0; i < k; i++)
      l = {l[5:0], l[6] ^ l[5]};
    return l[6];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [4:0] exp_at(input logic [W-1:0] p,
                                        input int g,
                                        input int t);
    int per;
    int o;
    per = W + g;
    o   = t % per;
    if (o < W)
      return {1'b1, o == 0, 1'b1, 1'b0, p[W-1-o]};
    return {1'b1, 1'b0, 1'b1, 1'b0,
            fill_bit((t / per) * g + (o - W))};
  endfunction

  function automatic int frame_len(input int r, input int g);
    if (r == 0) return 0;
    return r * W + (r - 1) * g;
  endfunction

  task automatic scramble();
    bus.pattern_in = W'($urandom);
    bus.repeat_cnt = CW'($urandom);
    bus.gap_len    = GW'($urandom);
  endtask

  // Full frame; optional abort after bit index ab (-1 = none)
  task automatic run_frame(input logic [W-1:0] p,
                           input int r, input int g,
                           input int ab, input string tag);
    int tot;
    tot = frame_len(r, g);
    @(negedge clk);
    bus.pattern_in = p;
    bus.repeat_cnt = CW'(r);
    bus.gap_len    = GW'(g);
    bus.start      = 1'b1;
    bus.abort      = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < tot; t++) begin
      check({tag, "_bit"}, 32'(obs()), 32'(exp_at(p, g, t)));
      scramble();
      bus.start = 1'($urandom);
      if (t == ab) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
          check({tag, "_abort"}, 32'(obs()), 32'h0);
          @(negedge clk);
        end
        return;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'($urandom);
    check({tag, "_done"}, 32'(obs()), 32'h2);
    @(negedge clk);
    bus.abort = 1'b0;
    check({tag, "_after"}, 32'(obs()), 32'h0);
  endtask

  initial begin
    int r;
    int g;
    int ab;
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.pattern_in = '0;
    bus.repeat_cnt = '0;
    bus.gap_len    = '0;
    repeat (2) @(negedge clk);
    check("reset", 32'(obs()), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("idle", 32'(obs()), 32'h0);

    run_frame(7'b0101011, 1, 0, -1, "t1");
    run_frame(7'b0101011, 3, 2, -1, "t2");
    run_frame(7'b0101011, 0, 0, -1, "t3");
    run_frame(7'b1100101, 2, 1, 4, "t4");
    run_frame(7'b0111000, 3, 3, 8, "t4g");

    // Reset asserted during the first gap of a 3x/gap-2 frame
    @(negedge clk);
    bus.pattern_in = 7'b0101011;
    bus.repeat_cnt = 8'd3;
    bus.gap_len    = 4'd2;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("gap_seen", 32'(obs()),
          32'(exp_at(7'b0101011, 2, 7)));
    #2 reset = 1'b0;
    #1 check("rst_async", 32'(obs()), 32'h0);
    @(negedge clk);
    check("rst_hold", 32'(obs()), 32'h0);
    reset = 1'b1;
    run_frame(7'b0101011, 1, 0, -1, "t5");

    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, 4);
      g  = $urandom_range(0, 15);
      ab = ($urandom_range(0, 3) == 0 && r > 0) ?
           $urandom_range(0, frame_len(r, g) - 1) : -1;
      run_frame(W'($urandom), r, g, ab, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
